// File: rtl/imm_decode_stage.sv
// Registered immediate-decode stage with a 2-entry skid buffer; one cycle latency, in_ready is purely registered.
// Optional CSR-immediate (Z format) decode is enabled by defining IMMGEN_ZICSR_EN.
module imm_decode_stage #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_inst,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_inst,
   output logic [TAG_W-1:0] out_tag,
   output logic [XLEN-1:0]  out_imm,
   output logic [2:0]       out_fmt
);

   localparam logic [2:0] FMT_NONE = 3'd0;
   localparam logic [2:0] FMT_I    = 3'd1;
   localparam logic [2:0] FMT_S    = 3'd2;
   localparam logic [2:0] FMT_B    = 3'd3;
   localparam logic [2:0] FMT_U    = 3'd4;
   localparam logic [2:0] FMT_J    = 3'd5;
`ifdef IMMGEN_ZICSR_EN
   localparam logic [2:0] FMT_Z    = 3'd6;
`endif

   logic [31:0]      dec_imm32;
   logic [2:0]       dec_fmt;
   logic [XLEN-1:0]  dec_imm;

   logic             skid_valid;
   logic [31:0]      skid_inst;
   logic [TAG_W-1:0] skid_tag;
   logic [XLEN-1:0]  skid_imm;
   logic [2:0]       skid_fmt;

   logic             in_fire;
   logic             out_fire;

   // Every format fits in 32 bits with bit 31 as the sign; widening happens once below.
   always_comb begin
      dec_imm32 = '0;
      dec_fmt   = FMT_NONE;
      case (in_inst[6:0])
         7'b0010011, 7'b0000011, 7'b1100111: begin
            dec_fmt   = FMT_I;
            dec_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
         end
         7'b0011011: begin
            if (XLEN == 64) begin
               dec_fmt   = FMT_I;
               dec_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
            end
         end
         7'b0100011: begin
            dec_fmt   = FMT_S;
            dec_imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
         end
         7'b1100011: begin
            dec_fmt   = FMT_B;
            dec_imm32 = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
         end
         7'b0110111, 7'b0010111: begin
            dec_fmt   = FMT_U;
            dec_imm32 = {in_inst[31:12], 12'b0};
         end
         7'b1101111: begin
            dec_fmt   = FMT_J;
            dec_imm32 = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
         end
`ifdef IMMGEN_ZICSR_EN
         7'b1110011: begin
            if (in_inst[14]) begin
               dec_fmt   = FMT_Z;
               dec_imm32 = {27'b0, in_inst[19:15]};
            end else begin
               dec_fmt   = FMT_I;
               dec_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
            end
         end
`endif
         default: begin
            dec_fmt   = FMT_NONE;
            dec_imm32 = '0;
         end
      endcase
   end

   generate
      if (XLEN == 64) begin : g_x64
         assign dec_imm = {{32{dec_imm32[31]}}, dec_imm32};
      end else if (XLEN == 32) begin : g_x32
         assign dec_imm = dec_imm32;
      end else begin : g_bad_xlen
         $error("imm_decode_stage: XLEN must be 32 or 64");
      end
   endgenerate

   assign in_ready = ~skid_valid;
   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         out_valid  <= 1'b0;
         out_inst   <= '0;
         out_tag    <= '0;
         out_imm    <= '0;
         out_fmt    <= FMT_NONE;
         skid_valid <= 1'b0;
         skid_inst  <= '0;
         skid_tag   <= '0;
         skid_imm   <= '0;
         skid_fmt   <= FMT_NONE;
      end else if (!out_valid) begin
         if (in_fire) begin
            out_valid <= 1'b1;
            out_inst  <= in_inst;
            out_tag   <= in_tag;
            out_imm   <= dec_imm;
            out_fmt   <= dec_fmt;
         end
      end else if (!skid_valid) begin
         if (in_fire && out_fire) begin
            out_inst <= in_inst;
            out_tag  <= in_tag;
            out_imm  <= dec_imm;
            out_fmt  <= dec_fmt;
         end else if (in_fire) begin
            skid_valid <= 1'b1;
            skid_inst  <= in_inst;
            skid_tag   <= in_tag;
            skid_imm   <= dec_imm;
            skid_fmt   <= dec_fmt;
         end else if (out_fire) begin
            out_valid <= 1'b0;
         end
      end else if (out_fire) begin
         // Both full: in_ready is low, so the only move is skid into main.
         skid_valid <= 1'b0;
         out_inst   <= skid_inst;
         out_tag    <= skid_tag;
         out_imm    <= skid_imm;
         out_fmt    <= skid_fmt;
      end
   end

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: XLEN=32 and XLEN=64 instances share stimulus and are checked against a queue model.
module tb_imm_decode_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_inst = '0;
   logic [7:0]  in_tag = '0;
   logic        out_ready = 1'b0;

   logic        rdy32, vld32, rdy64, vld64;
   logic [31:0] inst32, inst64;
   logic [7:0]  tag32, tag64;
   logic [31:0] imm32;
   logic [63:0] imm64;
   logic [2:0]  fmt32, fmt64;

   int checks = 0;
   int fails = 0;
   int delivered = 0;
   int accepted = 0;

   always #5 clk = ~clk;

   imm_decode_stage #(.XLEN(32), .TAG_W(8)) u_d32 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
      .in_inst(in_inst), .in_tag(in_tag), .out_valid(vld32), .out_ready(out_ready),
      .out_inst(inst32), .out_tag(tag32), .out_imm(imm32), .out_fmt(fmt32));

   imm_decode_stage #(.XLEN(64), .TAG_W(8)) u_d64 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
      .in_inst(in_inst), .in_tag(in_tag), .out_valid(vld64), .out_ready(out_ready),
      .out_inst(inst64), .out_tag(tag64), .out_imm(imm64), .out_fmt(fmt64));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      fails++;
      $display("FAIL %s bound expired t=%0t", name, $time);
   endtask

   // Reference decoder: value of the immediate as a signed integer, then truncated for XLEN=32.
   function automatic void ref_dec(input logic [31:0] i, input bit is64,
                                   output logic [63:0] imm, output logic [2:0] fmt);
      longint v;
      v   = 0;
      fmt = 3'd0;
      case (i[6:0])
         7'h13, 7'h03, 7'h67: begin fmt = 3'd1; v = longint'($signed(i[31:20])); end
         7'h1B: if (is64) begin fmt = 3'd1; v = longint'($signed(i[31:20])); end
         7'h23: begin fmt = 3'd2; v = longint'($signed({i[31:25], i[11:7]})); end
         7'h63: begin fmt = 3'd3; v = longint'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0})); end
         7'h37, 7'h17: begin fmt = 3'd4; v = longint'($signed({i[31:12], 12'h000})); end
         7'h6F: begin fmt = 3'd5; v = longint'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0})); end
`ifdef IMMGEN_ZICSR_EN
         7'h73: begin
            if (i[14]) begin fmt = 3'd6; v = longint'(i[19:15]); end
            else begin fmt = 3'd1; v = longint'($signed(i[31:20])); end
         end
`endif
         default: ;
      endcase
      imm = is64 ? 64'(v) : {32'h0, v[31:0]};
   endfunction

   typedef struct { logic [31:0] inst; logic [7:0] tag; } ent_t;
   ent_t q[$];
   bit   zero_exp = 1'b1;
   bit   hold_prev = 1'b0;
   logic [31:0] p_inst32, p_inst64;
   logic [7:0]  p_tag32, p_tag64;
   logic [31:0] p_imm32;
   logic [63:0] p_imm64;
   logic [2:0]  p_fmt32, p_fmt64;

   // Compare on the falling edge, then advance the model with the inputs the next rising edge will see.
   always @(negedge clk) begin
      logic [63:0] e_imm;
      logic [2:0]  e_fmt;
      bit          in_fire;
      ent_t        e;
      chk("vld32", 64'(vld32), 64'(q.size() > 0));
      chk("vld64", 64'(vld64), 64'(q.size() > 0));
      chk("rdy32", 64'(rdy32), 64'(q.size() < 2));
      chk("rdy64", 64'(rdy64), 64'(q.size() < 2));
      if (q.size() > 0) begin
         chk("inst32", 64'(inst32), 64'(q[0].inst));
         chk("inst64", 64'(inst64), 64'(q[0].inst));
         chk("tag32", 64'(tag32), 64'(q[0].tag));
         chk("tag64", 64'(tag64), 64'(q[0].tag));
         ref_dec(q[0].inst, 1'b0, e_imm, e_fmt);
         chk("imm32", 64'(imm32), e_imm);
         chk("fmt32", 64'(fmt32), 64'(e_fmt));
         ref_dec(q[0].inst, 1'b1, e_imm, e_fmt);
         chk("imm64", imm64, e_imm);
         chk("fmt64", 64'(fmt64), 64'(e_fmt));
      end else if (zero_exp) begin
         chk("zero_inst", 64'(inst32) | 64'(inst64) | 64'(tag32) | 64'(tag64), 64'h0);
         chk("zero_imm", 64'(imm32) | imm64, 64'h0);
         chk("zero_fmt", 64'(fmt32) | 64'(fmt64), 64'h0);
      end
      if (hold_prev) begin
         chk("hold32", {imm32, inst32}, {p_imm32, p_inst32});
         chk("hold64", imm64, p_imm64);
         chk("hold_misc", {40'h0, tag32, tag64, fmt32, fmt64, 2'b0}, {40'h0, p_tag32, p_tag64, p_fmt32, p_fmt64, 2'b0});
      end
      hold_prev = vld32 && !out_ready && !rst && !flush;
      p_inst32 = inst32; p_inst64 = inst64; p_tag32 = tag32; p_tag64 = tag64;
      p_imm32 = imm32; p_imm64 = imm64; p_fmt32 = fmt32; p_fmt64 = fmt64;
      if (rst || flush) begin
         q.delete();
         zero_exp = 1'b1;
      end else begin
         in_fire = in_valid && (q.size() < 2);
         if (q.size() > 0 && out_ready) begin
            void'(q.pop_front());
            delivered++;
         end
         if (in_fire) begin
            e.inst = in_inst;
            e.tag  = in_tag;
            q.push_back(e);
            zero_exp = 1'b0;
            accepted++;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] i, input logic [7:0] t);
      int n;
      in_valid = 1'b1;
      in_inst  = i;
      in_tag   = t;
      n = 0;
      while (1) begin
         @(negedge clk);
         if (rdy32) break;
         n++;
         if (n > 50) begin
            fail_now("send_wait");
            break;
         end
      end
      step();
      in_valid = 1'b0;
   endtask

   logic [6:0] ops [12] = '{7'h13, 7'h03, 7'h67, 7'h1B, 7'h23, 7'h63,
                            7'h37, 7'h17, 7'h6F, 7'h73, 7'h7F, 7'h33};

   initial begin
      int d0;
      int a0;
      int cyc;
      logic [31:0] r;
      step();
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_vld", 64'(vld32), 64'h0);
      chk("rst_rdy", 64'(rdy32), 64'h1);
      chk("rst_imm64", imm64, 64'h0);

      out_ready = 1'b1;
      send(32'hFFF00093, 8'h11);
      @(negedge clk);
      chk("addi_vld", 64'(vld32), 64'h1);
      chk("addi_imm32", 64'(imm32), 64'hFFFFFFFF);
      chk("addi_fmt", 64'(fmt32), 64'd1);
      chk("addi_tag", 64'(tag32), 64'h11);
      send(32'h800000B7, 8'h22);
      @(negedge clk);
      chk("lui_imm64", imm64, 64'hFFFFFFFF80000000);
      chk("lui_fmt", 64'(fmt64), 64'd4);
      send(32'hFE000EE3, 8'h33);
      @(negedge clk);
      chk("beq_imm64", imm64, 64'hFFFFFFFFFFFFFFFC);
      chk("beq_imm32", 64'(imm32), 64'hFFFFFFFC);
      chk("beq_fmt", 64'(fmt64), 64'd3);
      send(32'h0012D073, 8'h44);
      @(negedge clk);
`ifdef IMMGEN_ZICSR_EN
      chk("csr_fmt", 64'(fmt64), 64'd6);
      chk("csr_imm", imm64, 64'd5);
`else
      chk("csr_fmt", 64'(fmt64), 64'd0);
      chk("csr_imm", imm64, 64'd0);
`endif
      send(32'h0000007F, 8'h55);
      @(negedge clk);
      chk("unk_fmt", 64'(fmt32), 64'd0);
      chk("unk_imm", 64'(imm32), 64'd0);
      send(32'hFFF0809B, 8'h66);
      @(negedge clk);
      chk("addiw_imm64", imm64, 64'hFFFFFFFFFFFFFFFF);
      chk("addiw_fmt32", 64'(fmt32), 64'd0);
      step();

      // Backpressure: A held, B in skid, C refused until the stage drains.
      out_ready = 1'b0;
      d0 = delivered;
      send(32'h00500113, 8'hA1);
      send(32'h0040026F, 8'hB2);
      in_valid = 1'b1;
      in_inst  = 32'h00C12023;
      in_tag   = 8'hC3;
      @(negedge clk);
      chk("bp_rdy", 64'(rdy32), 64'h0);
      chk("bp_head", 64'(inst32), 64'h00500113);
      step();
      @(negedge clk);
      chk("bp_head2", 64'(tag32), 64'hA1);
      out_ready = 1'b1;
      send(32'h00C12023, 8'hC3);
      repeat (4) step();
      chk("bp_count", 64'(delivered - d0), 64'd3);

      // Flush while full, with a new instruction offered in the same cycle.
      out_ready = 1'b0;
      send(32'h00100093, 8'hD1);
      send(32'h00200093, 8'hD2);
      d0 = delivered;
      in_valid = 1'b1;
      in_inst  = 32'h00300093;
      in_tag   = 8'hD3;
      flush    = 1'b1;
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("fl_vld", 64'(vld32), 64'h0);
      chk("fl_rdy", 64'(rdy32), 64'h1);
      out_ready = 1'b1;
      repeat (3) step();
      chk("fl_none", 64'(delivered - d0), 64'd0);

      // Reset mid-stream.
      out_ready = 1'b0;
      send(32'hFFF00093, 8'hE1);
      send(32'h800000B7, 8'hE2);
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("rst2_vld", 64'(vld64), 64'h0);
      chk("rst2_imm", imm64, 64'h0);
      chk("rst2_tag", 64'(tag64), 64'h0);
      step();

      // Random traffic: 50% valid, 50% ready.
      a0  = accepted;
      cyc = 0;
      while (accepted - a0 < 10000 && cyc < 60000) begin
         r = $urandom();
         in_valid  = 1'($urandom_range(0, 1));
         in_inst   = {r[31:7], ops[$urandom_range(0, 11)]};
         in_tag    = 8'($urandom());
         out_ready = 1'($urandom_range(0, 1));
         step();
         cyc++;
      end
      if (accepted - a0 < 10000) fail_now("random_budget");
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (4) step();
      chk("drained", 64'(q.size()), 64'd0);
      chk("drained_vld", 64'(vld32), 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
